column_writer: RTL



---
 rtl/column_writer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/column_writer.sv
// Rasterises one screen column per wall height: ceiling, wall, then floor pixels.
// Optional: COLUMN_WRITER_SIDE_SHADE_EN halves the wall colour on y-side hits.
module column_writer #(
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter int          ADDR_W      = 19,
    parameter logic [11:0] CEIL_COLOR  = 12'h335,
    parameter logic [11:0] FLOOR_COLOR = 12'h642,
    parameter logic [11:0] WALL_COLOR  = 12'hCCC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        wall_height,
    input  logic              height_valid,
    input  logic              side,
    input  logic              write_new_frame,
    input  logic              fb_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic              busy,
    output logic              column_done,
    output logic              frame_done,
    output logic              overrun,
    output logic [9:0]        col_index
);

    typedef enum logic {IDLE, DRAW} state_t;

    localparam logic [9:0]        H_MAX    = 10'(SCREEN_H);
    localparam logic [9:0]        LAST_ROW = 10'(SCREEN_H - 1);
    localparam logic [9:0]        LAST_COL = 10'(SCREEN_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_W);

    state_t            state_q;
    logic [9:0]        row_q;
    logic [9:0]        top_q;
    logic [9:0]        bot_q;
    logic              side_q;
    logic [ADDR_W-1:0] addr_q;
    logic [9:0]        col_q;
    logic              pend_q;
    logic              overrun_q;
    logic              col_done_q;
    logic              frame_done_q;

    logic [9:0]  h_d;
    logic [9:0]  top_d;
    logic [11:0] wall_pix;
    logic [11:0] pix;

    assign h_d   = (wall_height > H_MAX) ? H_MAX : wall_height;
    assign top_d = (H_MAX - h_d) >> 1;

`ifdef COLUMN_WRITER_SIDE_SHADE_EN
    localparam logic [11:0] SHADE_COLOR = {1'b0, WALL_COLOR[11:9],
                                           1'b0, WALL_COLOR[7:5],
                                           1'b0, WALL_COLOR[3:1]};
    assign wall_pix = side_q ? SHADE_COLOR : WALL_COLOR;
`else
    assign wall_pix = side_q ? WALL_COLOR : WALL_COLOR;
`endif

    always_comb begin
        pix = FLOOR_COLOR;
        if (row_q < top_q)
            pix = CEIL_COLOR;
        else if (row_q < bot_q)
            pix = wall_pix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            top_q        <= '0;
            bot_q        <= '0;
            side_q       <= 1'b0;
            addr_q       <= '0;
            col_q        <= '0;
            pend_q       <= 1'b0;
            overrun_q    <= 1'b0;
            col_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (write_new_frame) begin
                        col_q     <= '0;
                        overrun_q <= 1'b0;
                    end
                    if (height_valid) begin
                        top_q   <= top_d;
                        bot_q   <= top_d + h_d;
                        side_q  <= side;
                        row_q   <= '0;
                        addr_q  <= write_new_frame ? '0 : ADDR_W'(col_q);
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    if (height_valid)
                        overrun_q <= 1'b1;
                    if (write_new_frame)
                        pend_q <= 1'b1;
                    if (fb_ready) begin
                        row_q  <= row_q + 10'd1;
                        addr_q <= addr_q + ROW_STEP;
                        if (row_q == LAST_ROW) begin
                            state_q    <= IDLE;
                            col_done_q <= 1'b1;
                            pend_q     <= 1'b0;
                            // a restart request beats the natural frame wrap
                            if (pend_q || write_new_frame) begin
                                col_q <= '0;
                            end else if (col_q == LAST_COL) begin
                                col_q        <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                col_q <= col_q + 10'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign fb_we       = (state_q == DRAW);
    assign busy        = (state_q == DRAW);
    assign fb_addr     = addr_q;
    assign fb_data     = (state_q == DRAW) ? pix : 12'h000;
    assign column_done = col_done_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign col_index   = col_q;

endmodule
